// File: rtl/init_sequencer_if.sv
// Control-bus side of the 8259-style init sequencer. The master drives the write strobes and
// the latched data byte; the slave returns the decoded ICW/OCW configuration.
interface init_sequencer_if;
  logic       write_ICW_1;
  logic       write_ICW2_4;
  logic       write_OCW1;
  logic       write_OCW2;
  logic       write_OCW3;
  logic [7:0] internal_bus;

  logic       ltim;
  logic       sngl;
  logic       ic4;
  logic [4:0] vector_base;
  logic [7:0] cascade_cfg;
  logic       upm;
  logic       aeoi;
  logic       ms;
  logic       buf_mode;
  logic       sfnm;
  logic [7:0] imr;
  logic       ocw2_valid;
  logic [2:0] ocw2_cmd;
  logic [2:0] ocw2_level;
  logic       rr;
  logic       ris;
  logic       smm;
  logic       poll_pulse;
  logic       init_done;

  modport master (
    output write_ICW_1, write_ICW2_4, write_OCW1, write_OCW2, write_OCW3, internal_bus,
    input  ltim, sngl, ic4, vector_base, cascade_cfg, upm, aeoi, ms, buf_mode, sfnm,
    input  imr, ocw2_valid, ocw2_cmd, ocw2_level, rr, ris, smm, poll_pulse, init_done
  );

  modport slave (
    input  write_ICW_1, write_ICW2_4, write_OCW1, write_OCW2, write_OCW3, internal_bus,
    output ltim, sngl, ic4, vector_base, cascade_cfg, upm, aeoi, ms, buf_mode, sfnm,
    output imr, ocw2_valid, ocw2_cmd, ocw2_level, rr, ris, smm, poll_pulse, init_done
  );
endinterface

// File: rtl/init_sequencer.sv
// 8259-style ICW1..ICW4 initialisation sequencer with OCW1/2/3 handling once READY.
//
// state     | meaning
// UNINIT    | after reset, waiting for ICW1
// WAIT_ICW2 | ICW1 taken, next ICW2_4 write is ICW2
// WAIT_ICW3 | cascade mode, next ICW2_4 write is ICW3
// WAIT_ICW4 | ic4 set, next ICW2_4 write is ICW4
// READY     | initialised, OCW writes accepted
module init_sequencer (
  input  logic               clk,
  input  logic               reset,
  init_sequencer_if.slave    bus_if
);

  typedef enum logic [2:0] {
    UNINIT    = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } state_e;

  state_e     state_q, state_d;

  logic [4:0] strb_now;
  logic [4:0] strb_hist_q;
  logic [4:0] strb_ev;
  logic       ev_icw1, ev_icw24, ev_ocw1, ev_ocw2, ev_ocw3;
  logic [7:0] bus;

  logic       ltim_q, ltim_d;
  logic       sngl_q, sngl_d;
  logic       ic4_q, ic4_d;
  logic [4:0] vector_base_q, vector_base_d;
  logic [7:0] cascade_cfg_q, cascade_cfg_d;
  logic       upm_q, upm_d;
  logic       aeoi_q, aeoi_d;
  logic       ms_q, ms_d;
  logic       buf_mode_q, buf_mode_d;
  logic       sfnm_q, sfnm_d;
  logic [7:0] imr_q, imr_d;
  logic       ocw2_valid_q, ocw2_valid_d;
  logic [2:0] ocw2_cmd_q, ocw2_cmd_d;
  logic [2:0] ocw2_level_q, ocw2_level_d;
  logic       rr_q, rr_d;
  logic       ris_q, ris_d;
  logic       smm_q, smm_d;
  logic       poll_pulse_q, poll_pulse_d;

  // A strobe held high is one write: only the 0->1 transition of the sampled level counts.
  assign strb_now = {bus_if.write_OCW3, bus_if.write_OCW2, bus_if.write_OCW1,
                     bus_if.write_ICW2_4, bus_if.write_ICW_1};
  assign strb_ev  = strb_now & ~strb_hist_q;
  assign ev_icw1  = strb_ev[0];
  assign ev_icw24 = strb_ev[1];
  assign ev_ocw1  = strb_ev[2];
  assign ev_ocw2  = strb_ev[3];
  assign ev_ocw3  = strb_ev[4];
  assign bus      = bus_if.internal_bus;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= UNINIT;
      strb_hist_q   <= 5'b0;
      ltim_q        <= 1'b0;
      sngl_q        <= 1'b0;
      ic4_q         <= 1'b0;
      vector_base_q <= 5'h00;
      cascade_cfg_q <= 8'h00;
      upm_q         <= 1'b0;
      aeoi_q        <= 1'b0;
      ms_q          <= 1'b0;
      buf_mode_q    <= 1'b0;
      sfnm_q        <= 1'b0;
      imr_q         <= 8'h00;
      ocw2_valid_q  <= 1'b0;
      ocw2_cmd_q    <= 3'd0;
      ocw2_level_q  <= 3'd0;
      rr_q          <= 1'b1;
      ris_q         <= 1'b0;
      smm_q         <= 1'b0;
      poll_pulse_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      strb_hist_q   <= strb_now;
      ltim_q        <= ltim_d;
      sngl_q        <= sngl_d;
      ic4_q         <= ic4_d;
      vector_base_q <= vector_base_d;
      cascade_cfg_q <= cascade_cfg_d;
      upm_q         <= upm_d;
      aeoi_q        <= aeoi_d;
      ms_q          <= ms_d;
      buf_mode_q    <= buf_mode_d;
      sfnm_q        <= sfnm_d;
      imr_q         <= imr_d;
      ocw2_valid_q  <= ocw2_valid_d;
      ocw2_cmd_q    <= ocw2_cmd_d;
      ocw2_level_q  <= ocw2_level_d;
      rr_q          <= rr_d;
      ris_q         <= ris_d;
      smm_q         <= smm_d;
      poll_pulse_q  <= poll_pulse_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ltim_d        = ltim_q;
    sngl_d        = sngl_q;
    ic4_d         = ic4_q;
    vector_base_d = vector_base_q;
    cascade_cfg_d = cascade_cfg_q;
    upm_d         = upm_q;
    aeoi_d        = aeoi_q;
    ms_d          = ms_q;
    buf_mode_d    = buf_mode_q;
    sfnm_d        = sfnm_q;
    imr_d         = imr_q;
    ocw2_valid_d  = 1'b0;
    ocw2_cmd_d    = ocw2_cmd_q;
    ocw2_level_d  = ocw2_level_q;
    rr_d          = rr_q;
    ris_d         = ris_q;
    smm_d         = smm_q;
    poll_pulse_d  = 1'b0;

    if (ev_icw1) begin
      // ICW1 restarts initialisation from any state and wins over every other strobe.
      ltim_d     = bus[3];
      sngl_d     = bus[1];
      ic4_d      = bus[0];
      imr_d      = 8'h00;
      smm_d      = 1'b0;
      rr_d       = 1'b1;
      ris_d      = 1'b0;
      upm_d      = 1'b0;
      aeoi_d     = 1'b0;
      ms_d       = 1'b0;
      buf_mode_d = 1'b0;
      sfnm_d     = 1'b0;
      state_d    = WAIT_ICW2;
    end else begin
      case (state_q)
        WAIT_ICW2: begin
          if (ev_icw24) begin
            vector_base_d = bus[7:3];
            if (!sngl_q)    state_d = WAIT_ICW3;
            else if (ic4_q) state_d = WAIT_ICW4;
            else            state_d = READY;
          end
        end
        WAIT_ICW3: begin
          if (ev_icw24) begin
            cascade_cfg_d = bus;
            state_d       = ic4_q ? WAIT_ICW4 : READY;
          end
        end
        WAIT_ICW4: begin
          if (ev_icw24) begin
            upm_d      = bus[0];
            aeoi_d     = bus[1];
            ms_d       = bus[2];
            buf_mode_d = bus[3];
            sfnm_d     = bus[4];
            state_d    = READY;
          end
        end
        READY: begin
          if (ev_ocw1) imr_d = bus;
          // OCW2 and OCW3 in the same cycle is an illegal decode; drop both.
          if (ev_ocw2 && !ev_ocw3) begin
            ocw2_valid_d = 1'b1;
            ocw2_cmd_d   = bus[7:5];
            ocw2_level_d = bus[2:0];
          end
          if (ev_ocw3 && !ev_ocw2) begin
            if (bus[1]) begin
              rr_d  = bus[1];
              ris_d = bus[0];
            end
            if (bus[6]) smm_d = bus[5];
            poll_pulse_d = bus[2];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_if.ltim        = ltim_q;
  assign bus_if.sngl        = sngl_q;
  assign bus_if.ic4         = ic4_q;
  assign bus_if.vector_base = vector_base_q;
  assign bus_if.cascade_cfg = cascade_cfg_q;
  assign bus_if.upm         = upm_q;
  assign bus_if.aeoi        = aeoi_q;
  assign bus_if.ms          = ms_q;
  assign bus_if.buf_mode    = buf_mode_q;
  assign bus_if.sfnm        = sfnm_q;
  assign bus_if.imr         = imr_q;
  assign bus_if.ocw2_valid  = ocw2_valid_q;
  assign bus_if.ocw2_cmd    = ocw2_cmd_q;
  assign bus_if.ocw2_level  = ocw2_level_q;
  assign bus_if.rr          = rr_q;
  assign bus_if.ris         = ris_q;
  assign bus_if.smm         = smm_q;
  assign bus_if.poll_pulse  = poll_pulse_q;
  assign bus_if.init_done   = (state_q == READY);

endmodule

// File: tb/tb_init_sequencer.sv
// Directed bench for init_sequencer: ICW sequences, OCW handling, edge detect and async reset.
module tb_init_sequencer;

  logic       clk;
  logic       reset;
  logic [4:0] strb;
  logic [7:0] data;

  int n_checks;
  int n_err;
  int n_ocw2_pulses;
  int n_poll_pulses;
  int base_ocw2;
  int base_poll;

  localparam int S_ICW1  = 0;
  localparam int S_ICW24 = 1;
  localparam int S_OCW1  = 2;
  localparam int S_OCW2  = 3;
  localparam int S_OCW3  = 4;

  init_sequencer_if sif ();

  assign sif.write_ICW_1  = strb[0];
  assign sif.write_ICW2_4 = strb[1];
  assign sif.write_OCW1   = strb[2];
  assign sif.write_OCW2   = strb[3];
  assign sif.write_OCW3   = strb[4];
  assign sif.internal_bus = data;

  init_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sif.ocw2_valid === 1'b1) n_ocw2_pulses++;
    if (sif.poll_pulse === 1'b1) n_poll_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise the strobes in mask for hold cycles, then idle two cycles.
  task automatic wr(input logic [4:0] mask, input logic [7:0] d, input int hold);
    @(negedge clk);
    data = d;
    strb = mask;
    repeat (hold) @(negedge clk);
    strb = 5'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_ltim"},   {31'b0, sif.ltim},     32'd0);
    chk({pfx, "_sngl"},   {31'b0, sif.sngl},     32'd0);
    chk({pfx, "_ic4"},    {31'b0, sif.ic4},      32'd0);
    chk({pfx, "_vbase"},  {27'b0, sif.vector_base}, 32'h0);
    chk({pfx, "_casc"},   {24'b0, sif.cascade_cfg}, 32'h0);
    chk({pfx, "_icw4"},   {27'b0, sif.sfnm, sif.buf_mode, sif.ms, sif.aeoi, sif.upm}, 32'h0);
    chk({pfx, "_imr"},    {24'b0, sif.imr},      32'h00);
    chk({pfx, "_rr"},     {31'b0, sif.rr},       32'd1);
    chk({pfx, "_ris"},    {31'b0, sif.ris},      32'd0);
    chk({pfx, "_smm"},    {31'b0, sif.smm},      32'd0);
    chk({pfx, "_pulses"}, {30'b0, sif.ocw2_valid, sif.poll_pulse}, 32'd0);
    chk({pfx, "_done"},   {31'b0, sif.init_done}, 32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_err         = 0;
    n_ocw2_pulses = 0;
    n_poll_pulses = 0;
    strb          = 5'b0;
    data          = 8'h00;
    reset         = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_state("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Writes before ICW1 are ignored.
    wr(5'b00100, 8'hAA, 1);
    chk("uninit_ocw1_imr", {24'b0, sif.imr}, 32'h00);
    wr(5'b00010, 8'hF8, 1);
    chk("uninit_icw2_vbase", {27'b0, sif.vector_base}, 32'h00);

    // Single mode with ICW4: ICW3 skipped.
    wr(5'b00001, 8'h13, 1);
    chk("a_icw1_flags", {29'b0, sif.ltim, sif.sngl, sif.ic4}, 32'b011);
    chk("a_icw1_done", {31'b0, sif.init_done}, 32'd0);
    wr(5'b00010, 8'h20, 1);
    chk("a_icw2_vbase", {27'b0, sif.vector_base}, 32'h04);
    chk("a_icw2_done", {31'b0, sif.init_done}, 32'd0);
    wr(5'b00010, 8'h01, 1);
    chk("a_icw4_upm", {31'b0, sif.upm}, 32'd1);
    chk("a_icw4_casc", {24'b0, sif.cascade_cfg}, 32'h00);
    chk("a_icw4_done", {31'b0, sif.init_done}, 32'd1);

    // READY: ICW2_4 ignored, OCW2 pulse once even when held.
    wr(5'b00010, 8'hF8, 1);
    chk("rdy_icw24_vbase", {27'b0, sif.vector_base}, 32'h04);
    base_ocw2 = n_ocw2_pulses;
    wr(5'b01000, 8'h65, 3);
    chk("ocw2_pulses", n_ocw2_pulses - base_ocw2, 32'd1);
    chk("ocw2_cmd", {29'b0, sif.ocw2_cmd}, 32'd3);
    chk("ocw2_level", {29'b0, sif.ocw2_level}, 32'd5);

    base_poll = n_poll_pulses;
    wr(5'b10000, 8'h6B, 1);
    chk("ocw3a_rr_ris_smm", {29'b0, sif.rr, sif.ris, sif.smm}, 32'b111);
    chk("ocw3a_poll", n_poll_pulses - base_poll, 32'd0);
    base_poll = n_poll_pulses;
    wr(5'b10000, 8'h0C, 2);
    chk("ocw3b_poll", n_poll_pulses - base_poll, 32'd1);
    chk("ocw3b_rr_ris_smm", {29'b0, sif.rr, sif.ris, sif.smm}, 32'b111);

    // OCW2 with OCW3 together is illegal: both dropped.
    base_ocw2 = n_ocw2_pulses;
    base_poll = n_poll_pulses;
    wr(5'b11000, 8'h44, 1);
    chk("ocw23_ocw2_pulses", n_ocw2_pulses - base_ocw2, 32'd0);
    chk("ocw23_poll", n_poll_pulses - base_poll, 32'd0);
    chk("ocw23_level", {29'b0, sif.ocw2_level}, 32'd5);
    chk("ocw23_rr_ris_smm", {29'b0, sif.rr, sif.ris, sif.smm}, 32'b111);

    wr(5'b00100, 8'hFF, 1);
    chk("rdy_ocw1_imr", {24'b0, sif.imr}, 32'hFF);

    // ICW1 held three cycles with an ICW2 write in the middle: must count once.
    @(negedge clk);
    data = 8'h13;
    strb = 5'b00001;
    @(negedge clk);
    chk("re_icw1_done", {31'b0, sif.init_done}, 32'd0);
    chk("re_icw1_imr", {24'b0, sif.imr}, 32'h00);
    chk("re_icw1_rr_ris_smm", {29'b0, sif.rr, sif.ris, sif.smm}, 32'b100);
    data = 8'h30;
    strb = 5'b00011;
    @(negedge clk);
    data = 8'h13;
    strb = 5'b00001;
    @(negedge clk);
    strb = 5'b00000;
    repeat (2) @(negedge clk);
    chk("re_icw2_vbase", {27'b0, sif.vector_base}, 32'h06);
    wr(5'b00010, 8'h02, 1);
    chk("re_icw4_aeoi_upm", {30'b0, sif.aeoi, sif.upm}, 32'b10);
    chk("re_icw4_done", {31'b0, sif.init_done}, 32'd1);

    // Cascade mode through ICW3 then OCW1.
    wr(5'b00001, 8'h11, 1);
    chk("b_icw1_flags", {29'b0, sif.ltim, sif.sngl, sif.ic4}, 32'b001);
    wr(5'b00010, 8'h08, 1);
    chk("b_icw2_vbase", {27'b0, sif.vector_base}, 32'h01);
    chk("b_icw2_casc", {24'b0, sif.cascade_cfg}, 32'h00);
    wr(5'b00010, 8'h04, 1);
    chk("b_icw3_casc", {24'b0, sif.cascade_cfg}, 32'h04);
    chk("b_icw3_done", {31'b0, sif.init_done}, 32'd0);
    wr(5'b00010, 8'h03, 1);
    chk("b_icw4_aeoi_upm", {30'b0, sif.aeoi, sif.upm}, 32'b11);
    chk("b_icw4_done", {31'b0, sif.init_done}, 32'd1);
    wr(5'b00100, 8'hFB, 1);
    chk("b_ocw1_imr", {24'b0, sif.imr}, 32'hFB);

    // ICW2 and OCW1 together in WAIT_ICW2; OCW2 ignored before READY.
    wr(5'b00001, 8'h1B, 1);
    chk("c_icw1_flags", {29'b0, sif.ltim, sif.sngl, sif.ic4}, 32'b111);
    wr(5'b00110, 8'h40, 1);
    chk("c_icw2_vbase", {27'b0, sif.vector_base}, 32'h08);
    chk("c_icw2_imr", {24'b0, sif.imr}, 32'h00);
    base_ocw2 = n_ocw2_pulses;
    wr(5'b01000, 8'hE7, 1);
    chk("c_ocw2_ignored", n_ocw2_pulses - base_ocw2, 32'd0);
    chk("c_ocw2_cmd_held", {29'b0, sif.ocw2_cmd}, 32'd3);
    wr(5'b00010, 8'h1C, 1);
    chk("c_icw4_fields", {27'b0, sif.sfnm, sif.buf_mode, sif.ms, sif.aeoi, sif.upm}, 32'h1C);

    // Reset between ICW2 and ICW4, applied mid-cycle.
    wr(5'b00001, 8'h13, 1);
    wr(5'b00010, 8'h20, 1);
    chk("d_icw2_vbase", {27'b0, sif.vector_base}, 32'h04);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_state("async");
    @(negedge clk);
    reset = 1'b0;
    wr(5'b00010, 8'h01, 1);
    chk("d_icw4_upm", {31'b0, sif.upm}, 32'd0);
    chk("d_icw4_done", {31'b0, sif.init_done}, 32'd0);
    chk("d_icw4_vbase", {27'b0, sif.vector_base}, 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
